// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake between the core and the data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master(output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                 input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave(input req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word RAM answering RV32I loads/stores with byte merging, extension and fault responses
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input logic clk,
  input logic rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] off, wdata_q, word, shifted, rdata_n, wrep;
  logic [AW-1:0] idx_q;
  logic [1:0] lane_q;
  logic [2:0] f3_q;
  logic [3:0] be;
  logic we_q, err_q, err_n, legal, misal, accept, enter, consume;
  assign accept  = bus.req_valid && bus.req_ready;
  assign consume = bus.resp_valid && bus.resp_ready;
  assign off     = bus.req_addr - BASE_ADDR;
  assign legal   = bus.req_we ? (bus.req_funct3 <= 3'd2)
                              : (bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign misal   = (bus.req_funct3[1:0] == 2'd1 && off[0]) ||
                   (bus.req_funct3[1:0] == 2'd2 && off[1:0] != 2'd0);
  assign err_n   = (|off[31:AW+2]) || !legal || misal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        state_n = (LATENCY == 1) ? RESP : WAIT;
        cnt_n   = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
      end
      WAIT: begin
        cnt_n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt == 4'd0) state_n = RESP;
      end
      RESP: if (consume) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      idx_q   <= off[AW+1:2];
      lane_q  <= off[1:0];
      wdata_q <= bus.req_wdata;
      err_q   <= err_n;
    end
  assign enter   = state_n == RESP && state != RESP;
  assign word    = mem[idx_q];
  assign shifted = word >> {lane_q, 3'b000};
  assign rdata_n = (we_q || err_q)  ? 32'h0 :
                   (f3_q == 3'd0)   ? {{24{shifted[7]}}, shifted[7:0]} :
                   (f3_q == 3'd1)   ? {{16{shifted[15]}}, shifted[15:0]} :
                   (f3_q == 3'd4)   ? {24'h0, shifted[7:0]} :
                   (f3_q == 3'd5)   ? {16'h0, shifted[15:0]} : word;
  assign be      = (f3_q[1:0] == 2'd0) ? 4'b0001 << lane_q :
                   (f3_q[1:0] == 2'd1) ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wrep    = (f3_q[1:0] == 2'd0) ? {4{wdata_q[7:0]}} :
                   (f3_q[1:0] == 2'd1) ? {2{wdata_q[15:0]}} : wdata_q;
  // Stores commit on the edge entering RESP so a later load always sees them
  always_ff @(posedge clk)
    if (rst_n && enter && we_q && !err_q)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx_q][8*i +: 8] <= wrep[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.req_ready  <= state_n == IDLE;
      bus.resp_valid <= state == RESP && state_n == RESP;
      if (enter) begin
        bus.resp_rdata <= rdata_n;
        bus.resp_err   <= err_q;
      end else if (consume) begin
        bus.resp_rdata <= '0;
        bus.resp_err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-level memory model
module tb_dmem_responder;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errs = 0;
  always #5 clk = ~clk;
  dmem_responder_if bus();
  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] mdl [int unsigned];
  logic busy = 1'b0, pend_v = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rd = '0, pword = '0;
  int unsigned pidx = 0;
  int age = 0;
  logic [31:0] rd;
  logic er;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] mbyte(input int unsigned a);
    logic [31:0] w;
    w = mdl.exists(a / 4) ? mdl[a / 4] : 32'h0;
    return w[8*(a%4) +: 8];
  endfunction
  // Expected response from the RV32I rules, viewing memory as bytes
  task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int unsigned off, sz;
    logic [31:0] v, w;
    logic e;
    off = a - BASE;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e = off >= DEPTH * 4 || (we ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || off % sz != 0;
    exp_err = e;
    exp_rd = 32'h0;
    pend_v = 1'b0;
    if (!e && !we) begin
      v = 32'h0;
      for (int b = 0; b < int'(sz); b++) v |= 32'(mbyte(off + b)) << (8 * b);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
      exp_rd = v;
    end
    if (!e && we) begin
      w = mdl.exists(off / 4) ? mdl[off / 4] : 32'h0;
      for (int b = 0; b < int'(sz); b++) w[8*((off+b)%4) +: 8] = wd[8*b +: 8];
      pend_v = 1'b1;
      pidx = off / 4;
      pword = w;
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      pend_v = 1'b0;
      age = 0;
    end else begin
      chk("req_ready", bus.req_ready, !busy);
      chk("resp_valid", bus.resp_valid, busy && age >= LAT);
      if (bus.resp_valid) begin
        chk("resp_rdata", bus.resp_rdata, exp_rd);
        chk("resp_err", bus.resp_err, exp_err);
      end else if (!busy) begin
        chk("idle_rdata", bus.resp_rdata, 32'h0);
        chk("idle_err", bus.resp_err, 32'h0);
      end
      if (busy && bus.resp_valid && bus.resp_ready) busy = 1'b0;
      else if (busy) age++;
      else if (bus.req_valid) begin
        predict(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata);
        busy = 1'b1;
        age = 0;
      end
      if (busy && age == LAT - 1 && pend_v) begin
        mdl[pidx] = pword;
        pend_v = 1'b0;
      end
    end
  end
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input int hold, output logic [31:0] rdo, output logic ero);
    int n;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) chk("accept_timeout", bus.req_ready, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'($urandom % 2);
    bus.req_we = 1'($urandom % 2);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 50);
    if (!bus.resp_valid) chk("resp_timeout", bus.resp_valid, 32'h1);
    rdo = bus.resp_rdata;
    ero = bus.resp_err;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] r;
    logic w;
    logic [2:0] f;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 32'h1);
    chk("rst_resp_valid", bus.resp_valid, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", bus.resp_err, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    xact(1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    chk("sw_err", er, 32'h0);
    xact(0, 3'd2, BASE + 32'h10, 0, 0, rd, er);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_err", er, 32'h0);
    xact(1, 3'd2, BASE + 32'h20, 32'h80FF_7F01, 0, rd, er);
    xact(0, 3'd0, BASE + 32'h23, 0, 1, rd, er);
    chk("lb", rd, 32'hFFFF_FF80);
    xact(0, 3'd4, BASE + 32'h23, 0, 0, rd, er);
    chk("lbu", rd, 32'h0000_0080);
    xact(0, 3'd1, BASE + 32'h22, 0, 2, rd, er);
    chk("lh", rd, 32'hFFFF_80FF);
    xact(0, 3'd5, BASE + 32'h20, 0, 0, rd, er);
    chk("lhu", rd, 32'h0000_7F01);
    xact(1, 3'd2, BASE + 32'h30, 32'h1122_3344, 0, rd, er);
    xact(1, 3'd0, BASE + 32'h31, 32'h0000_00AA, 0, rd, er);
    xact(1, 3'd1, BASE + 32'h32, 32'h0000_5566, 0, rd, er);
    xact(0, 3'd2, BASE + 32'h30, 0, 0, rd, er);
    chk("merge", rd, 32'h5566_AA44);
    xact(1, 3'd2, BASE, 32'hCAFE_F00D, 0, rd, er);
    xact(0, 3'd2, BASE + 32'h2, 0, 0, rd, er);
    chk("lw_mis_err", er, 32'h1);
    chk("lw_mis_data", rd, 32'h0);
    xact(1, 3'd1, BASE + 32'h1, 32'h1234_5678, 0, rd, er);
    chk("sh_mis_err", er, 32'h1);
    xact(0, 3'd2, BASE + 32'(4 * DEPTH), 0, 0, rd, er);
    chk("oor_err", er, 32'h1);
    chk("oor_data", rd, 32'h0);
    xact(0, 3'd3, BASE, 0, 0, rd, er);
    chk("f3_err", er, 32'h1);
    xact(0, 3'd2, BASE, 0, 0, rd, er);
    chk("unchanged", rd, 32'hCAFE_F00D);
    xact(0, 3'd2, BASE + 32'h10, 0, 5, rd, er);
    chk("bp_data", rd, 32'hDEAD_BEEF);
    xact(1, 3'd2, BASE + 32'(4 * DEPTH - 4), 32'h1357_9BDF, 0, rd, er);
    xact(0, 3'd2, BASE + 32'(4 * DEPTH - 4), 0, 0, rd, er);
    chk("top_word", rd, 32'h1357_9BDF);
    // Reset while a store is still waiting must discard it
    xact(1, 3'd2, BASE + 32'h100, 32'h0, 0, rd, er);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr = BASE + 32'h100;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 32'h1);
    chk("arst_resp_valid", bus.resp_valid, 32'h0);
    chk("arst_rdata", bus.resp_rdata, 32'h0);
    chk("arst_err", bus.resp_err, 32'h0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    xact(0, 3'd2, BASE + 32'h100, 0, 0, rd, er);
    chk("discarded", rd, 32'h0);
    for (int i = 0; i < 8; i++) xact(1, 3'd2, BASE + 32'h40 + 32'(4 * i), $urandom, 0, rd, er);
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom % 2);
      f = ($urandom % 8 == 0) ? 3'($urandom) : w ? 3'($urandom % 3) : lf[$urandom % 5];
      r = ($urandom % 10 == 0) ? BASE + 32'(4 * DEPTH) + 32'($urandom % 64) : BASE + 32'h40 + 32'($urandom % 32);
      xact(w, f, r, $urandom, int'($urandom % 3), rd, er);
    end
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
